// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB control FSM with RAM/IO windows and sticky trap.
// Optional RV32M_EN: decodes mul/mulh/div/rem and stalls EXEC until alu_done.
module multicycle_control #(
    parameter int                   ADDR_HI_W      = 22,
    parameter logic [ADDR_HI_W-1:0] IO_HIGH        = 22'h3FFFFF,
    parameter logic [ADDR_HI_W-1:0] RAM_LIMIT_HIGH = 22'h000040,
    parameter int                   MEM_WAIT       = 1,
    parameter int                   IO_TIMEOUT     = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          instruction,
    input  logic                 instr_valid,
    input  logic [ADDR_HI_W-1:0] alu_result_high,
    input  logic                 io_ready,
    input  logic                 alu_done,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic [3:0]           ALUop,
    output logic                 ALUSrc,
    output logic                 sftmd,
    output logic [2:0]           branch_type,
    output logic                 jal,
    output logic                 jalr,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 IORead,
    output logic                 IOWrite,
    output logic                 MemorIOToReg,
    output logic                 RegWrite,
    output logic [2:0]           state,
    output logic                 trap,
    output logic [1:0]           trap_cause
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       sftmd;
        logic [2:0] br;
        logic       jal;
        logic       jalr;
        logic       load;
        logic       store;
        logic       branch;
        logic       muldiv;
    } ctrl_t;

    state_t      st, st_nx;
    logic [31:0] ir;
    ctrl_t       ctl, dec;
    logic        dec_ok;
    logic        is_ram, is_io;
    logic [7:0]  cnt;
    logic        st_pc;
    logic [1:0]  cause, cause_nx;
    logic        unused_bits;

    logic [6:0] opc, f7;
    logic [2:0] f3;
    assign opc = ir[6:0];
    assign f3  = ir[14:12];
    assign f7  = ir[31:25];

`ifdef RV32M_EN
    assign unused_bits = ^{ir[24:15], ir[11:7]};
`else
    assign unused_bits = ^{ir[24:15], ir[11:7], alu_done};
`endif

    assign state = st;

    always_comb begin
        dec    = '0;
        dec_ok = 1'b1;
        unique case (opc)
            7'b0110011: begin
                unique case ({f7, f3})
                    {7'h00, 3'd0}: dec.alu_op = 4'd0;
                    {7'h20, 3'd0}: dec.alu_op = 4'd1;
                    {7'h00, 3'd4}: dec.alu_op = 4'd2;
                    {7'h00, 3'd6}: dec.alu_op = 4'd3;
                    {7'h00, 3'd7}: dec.alu_op = 4'd4;
                    {7'h00, 3'd1}: begin dec.alu_op = 4'd5; dec.sftmd = 1'b1; end
                    {7'h00, 3'd5}: begin dec.alu_op = 4'd6; dec.sftmd = 1'b1; end
                    {7'h20, 3'd5}: begin dec.alu_op = 4'd7; dec.sftmd = 1'b1; end
`ifdef RV32M_EN
                    {7'h01, 3'd0}: begin dec.alu_op = 4'hA; dec.muldiv = 1'b1; end
                    {7'h01, 3'd1}: begin dec.alu_op = 4'hB; dec.muldiv = 1'b1; end
                    {7'h01, 3'd4}: begin dec.alu_op = 4'hC; dec.muldiv = 1'b1; end
                    {7'h01, 3'd6}: begin dec.alu_op = 4'hD; dec.muldiv = 1'b1; end
`endif
                    default: dec_ok = 1'b0;
                endcase
            end
            7'b0010011: begin
                dec.alu_src = 1'b1;
                unique case (f3)
                    3'd0: dec.alu_op = 4'd0;
                    3'd4: dec.alu_op = 4'd2;
                    3'd6: dec.alu_op = 4'd3;
                    3'd7: dec.alu_op = 4'd4;
                    3'd1: begin
                        dec.alu_op = 4'd5;
                        dec.sftmd  = 1'b1;
                        dec_ok     = (f7 == 7'h00);
                    end
                    3'd5: begin
                        dec.alu_op = (f7 == 7'h20) ? 4'd7 : 4'd6;
                        dec.sftmd  = 1'b1;
                        dec_ok     = (f7 == 7'h00) || (f7 == 7'h20);
                    end
                    default: dec_ok = 1'b0;
                endcase
            end
            7'b0000011: begin
                dec.alu_src = 1'b1;
                dec.load    = 1'b1;
                dec_ok      = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
            end
            7'b0100011: begin
                dec.alu_src = 1'b1;
                dec.store   = 1'b1;
                dec_ok      = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
            end
            7'b1100011: begin
                dec.alu_op = 4'd1;
                dec.branch = 1'b1;
                unique case (f3)
                    3'd0: dec.br = 3'd1;
                    3'd1: dec.br = 3'd2;
                    3'd4: dec.br = 3'd3;
                    3'd5: dec.br = 3'd4;
                    3'd6: dec.br = 3'd5;
                    3'd7: dec.br = 3'd6;
                    default: dec_ok = 1'b0;
                endcase
            end
            7'b1101111: dec.jal = 1'b1;
            7'b1100111: begin
                dec.jalr    = 1'b1;
                dec.alu_src = 1'b1;
                dec_ok      = (f3 == 3'd0);
            end
            7'b0110111: begin dec.alu_op = 4'd8; dec.alu_src = 1'b1; end
            7'b0010111: begin dec.alu_op = 4'd9; dec.alu_src = 1'b1; end
            default: dec_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= S_FETCH;
            ir     <= '0;
            ctl    <= '0;
            is_ram <= 1'b0;
            is_io  <= 1'b0;
            cnt    <= '0;
            st_pc  <= 1'b0;
            cause  <= '0;
        end else begin
            st <= st_nx;
            if (st == S_FETCH && instr_valid)
                ir <= instruction;
            if (st == S_DECODE)
                ctl <= dec;
            if (st == S_EXEC && st_nx == S_MEM) begin
                is_io  <= (alu_result_high == IO_HIGH);
                is_ram <= (alu_result_high < RAM_LIMIT_HIGH);
            end
            cnt   <= (st == S_MEM) ? cnt + 8'd1 : 8'd1;
            st_pc <= (st == S_MEM) && (st_nx == S_FETCH);
            if (st != S_TRAP && st_nx == S_TRAP)
                cause <= cause_nx;
        end
    end

    always_comb begin
        st_nx        = st;
        cause_nx     = cause;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        ALUop        = '0;
        ALUSrc       = 1'b0;
        sftmd        = 1'b0;
        branch_type  = '0;
        jal          = 1'b0;
        jalr         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IORead       = 1'b0;
        IOWrite      = 1'b0;
        MemorIOToReg = 1'b0;
        RegWrite     = 1'b0;
        trap         = 1'b0;
        trap_cause   = '0;
        unique case (st)
            S_FETCH: begin
                // reset gates the one output driven by a live input
                ir_write = instr_valid & rst_n;
                pc_write = st_pc;
                if (instr_valid)
                    st_nx = S_DECODE;
            end
            S_DECODE: begin
                if (dec_ok) begin
                    st_nx = S_EXEC;
                end else begin
                    st_nx    = S_TRAP;
                    cause_nx = 2'd0;
                end
            end
            S_EXEC: begin
                ALUop       = ctl.alu_op;
                ALUSrc      = ctl.alu_src;
                sftmd       = ctl.sftmd;
                branch_type = ctl.br;
                jal         = ctl.jal;
                jalr        = ctl.jalr;
                if (ctl.load || ctl.store) begin
                    st_nx = S_MEM;
                end else if (ctl.branch) begin
                    pc_write = 1'b1;
                    st_nx    = S_FETCH;
                end else if (ctl.muldiv) begin
`ifdef RV32M_EN
                    if (alu_done)
                        st_nx = S_WB;
`else
                    st_nx = S_WB;
`endif
                end else begin
                    st_nx = S_WB;
                end
            end
            S_MEM: begin
                if (is_io) begin
                    IORead  = ctl.load;
                    IOWrite = ctl.store;
                    if (io_ready) begin
                        st_nx = ctl.load ? S_WB : S_FETCH;
                    end else if (cnt == 8'(IO_TIMEOUT)) begin
                        st_nx    = S_TRAP;
                        cause_nx = 2'd2;
                    end
                end else if (is_ram) begin
                    MemRead  = ctl.load;
                    MemWrite = ctl.store;
                    if (cnt == 8'(MEM_WAIT))
                        st_nx = ctl.load ? S_WB : S_FETCH;
                end else begin
                    st_nx    = S_TRAP;
                    cause_nx = 2'd1;
                end
            end
            S_WB: begin
                RegWrite     = 1'b1;
                pc_write     = 1'b1;
                jal          = ctl.jal;
                jalr         = ctl.jalr;
                MemorIOToReg = ctl.load;
                st_nx        = S_FETCH;
            end
            S_TRAP: begin
                trap       = 1'b1;
                trap_cause = cause;
            end
            default: st_nx = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed self-checking bench for multicycle_control.
// Runs with MEM_WAIT=2; the mul test adapts to RV32M_EN.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [21:0] alu_result_high;
    logic        io_ready;
    logic        alu_done;
    logic        ir_write, pc_write, ALUSrc, sftmd, jal, jalr;
    logic [3:0]  ALUop;
    logic [2:0]  branch_type, state;
    logic        MemRead, MemWrite, IORead, IOWrite;
    logic        MemorIOToReg, RegWrite, trap;
    logic [1:0]  trap_cause;
    logic [21:0] outs;

    int checks = 0;
    int errors = 0;

    localparam logic [21:0] IO_A  = 22'h3FFFFF;
    localparam logic [31:0] ADD   = 32'h002081B3;
    localparam logic [31:0] SUB   = 32'h402081B3;
    localparam logic [31:0] SRAI  = 32'h4030D093;
    localparam logic [31:0] LW    = 32'h0000A283;
    localparam logic [31:0] SW    = 32'h0020A023;
    localparam logic [31:0] BEQ   = 32'h00208063;
    localparam logic [31:0] BNE   = 32'h00209063;
    localparam logic [31:0] JAL   = 32'h000000EF;
    localparam logic [31:0] ILL   = 32'h0000007F;
    localparam logic [31:0] MUL   = 32'h022081B3;

    always #5 clk = ~clk;

    assign outs = {ir_write, pc_write, ALUop, ALUSrc, sftmd, branch_type,
                   jal, jalr, MemRead, MemWrite, IORead, IOWrite,
                   MemorIOToReg, RegWrite, trap, trap_cause};

    multicycle_control #(.MEM_WAIT(2)) dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction),
        .instr_valid(instr_valid), .alu_result_high(alu_result_high),
        .io_ready(io_ready), .alu_done(alu_done),
        .ir_write(ir_write), .pc_write(pc_write), .ALUop(ALUop),
        .ALUSrc(ALUSrc), .sftmd(sftmd), .branch_type(branch_type),
        .jal(jal), .jalr(jalr), .MemRead(MemRead), .MemWrite(MemWrite),
        .IORead(IORead), .IOWrite(IOWrite), .MemorIOToReg(MemorIOToReg),
        .RegWrite(RegWrite), .state(state), .trap(trap),
        .trap_cause(trap_cause)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        instruction = '0;
        instr_valid = 1'b0;
        alu_result_high = '0;
        io_ready = 1'b0;
        alu_done = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic fetch(input logic [31:0] ins);
        instruction = ins;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        instruction = '0;
        step();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        instruction = ADD;
        instr_valid = 1'b1;
        alu_result_high = '0;
        io_ready = 1'b0;
        alu_done = 1'b0;
        #2;
        checks++;
        if (outs !== 22'd0) begin
            errors++;
            $display("FAIL reset_outs: got %h expected 0", outs);
        end
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d expected 0", state);
        end
        do_reset();
    endtask

    task automatic test_add;
        instruction = ADD;
        instr_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (ir_write !== 1'b1 || state !== 3'd0) begin
            errors++;
            $display("FAIL add_fetch: ir_write=%b state=%0d expected 1/0", ir_write, state);
        end
        step();
        instr_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 3'd1 || ir_write !== 1'b0) begin
            errors++;
            $display("FAIL add_decode: state=%0d ir_write=%b expected 1/0", state, ir_write);
        end
        step();
        @(negedge clk);
        checks++;
        if (state !== 3'd2 || ALUop !== 4'd0 || ALUSrc !== 1'b0 || RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL add_exec: state=%0d ALUop=%0d ALUSrc=%b RegWrite=%b expected 2/0/0/0",
                     state, ALUop, ALUSrc, RegWrite);
        end
        step();
        @(negedge clk);
        checks++;
        if (state !== 3'd4 || RegWrite !== 1'b1 || pc_write !== 1'b1) begin
            errors++;
            $display("FAIL add_wb: state=%0d RegWrite=%b pc_write=%b expected 4/1/1",
                     state, RegWrite, pc_write);
        end
        step();
        @(negedge clk);
        checks++;
        if (state !== 3'd0 || RegWrite !== 1'b0 || pc_write !== 1'b0) begin
            errors++;
            $display("FAIL add_done: state=%0d RegWrite=%b pc_write=%b expected 0/0/0",
                     state, RegWrite, pc_write);
        end
    endtask

    task automatic test_back_to_back;
        fetch(SUB);
        @(negedge clk);
        checks++;
        if (ALUop !== 4'd1 || sftmd !== 1'b0) begin
            errors++;
            $display("FAIL sub_exec: ALUop=%0d sftmd=%b expected 1/0", ALUop, sftmd);
        end
        step();
        step();
        fetch(SRAI);
        @(negedge clk);
        checks++;
        if (ALUop !== 4'd7 || sftmd !== 1'b1 || ALUSrc !== 1'b1) begin
            errors++;
            $display("FAIL srai_exec: ALUop=%0d sftmd=%b ALUSrc=%b expected 7/1/1",
                     ALUop, sftmd, ALUSrc);
        end
        step();
        step();
    endtask

    task automatic test_branch;
        fetch(BEQ);
        @(negedge clk);
        checks++;
        if (state !== 3'd2 || branch_type !== 3'd1 || pc_write !== 1'b1 || RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL beq_exec: state=%0d br=%0d pc_write=%b RegWrite=%b expected 2/1/1/0",
                     state, branch_type, pc_write, RegWrite);
        end
        step();
        @(negedge clk);
        checks++;
        if (state !== 3'd0 || pc_write !== 1'b0) begin
            errors++;
            $display("FAIL beq_done: state=%0d pc_write=%b expected 0/0", state, pc_write);
        end
        fetch(BNE);
        @(negedge clk);
        checks++;
        if (branch_type !== 3'd2 || pc_write !== 1'b1) begin
            errors++;
            $display("FAIL bne_exec: br=%0d pc_write=%b expected 2/1", branch_type, pc_write);
        end
        step();
    endtask

    task automatic test_jal;
        fetch(JAL);
        @(negedge clk);
        checks++;
        if (state !== 3'd2 || jal !== 1'b1 || jalr !== 1'b0) begin
            errors++;
            $display("FAIL jal_exec: state=%0d jal=%b jalr=%b expected 2/1/0", state, jal, jalr);
        end
        step();
        @(negedge clk);
        checks++;
        if (state !== 3'd4 || jal !== 1'b1 || RegWrite !== 1'b1) begin
            errors++;
            $display("FAIL jal_wb: state=%0d jal=%b RegWrite=%b expected 4/1/1", state, jal, RegWrite);
        end
        step();
        @(negedge clk);
        checks++;
        if (jal !== 1'b0) begin
            errors++;
            $display("FAIL jal_clear: got %b expected 0", jal);
        end
    endtask

    task automatic test_load_ram;
        fetch(LW);
        alu_result_high = 22'h000010;
        @(negedge clk);
        checks++;
        if (state !== 3'd2 || ALUSrc !== 1'b1 || MemRead !== 1'b0) begin
            errors++;
            $display("FAIL lw_exec: state=%0d ALUSrc=%b MemRead=%b expected 2/1/0",
                     state, ALUSrc, MemRead);
        end
        step();
        alu_result_high = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (state !== 3'd3 || MemRead !== 1'b1 || IORead !== 1'b0) begin
                errors++;
                $display("FAIL lw_mem%0d: state=%0d MemRead=%b IORead=%b expected 3/1/0",
                         i, state, MemRead, IORead);
            end
            step();
        end
        @(negedge clk);
        checks++;
        if (state !== 3'd4 || MemRead !== 1'b0 || MemorIOToReg !== 1'b1 || RegWrite !== 1'b1) begin
            errors++;
            $display("FAIL lw_wb: state=%0d MemRead=%b M2R=%b RegWrite=%b expected 4/0/1/1",
                     state, MemRead, MemorIOToReg, RegWrite);
        end
        step();
        @(negedge clk);
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL lw_done: state=%0d expected 0", state);
        end
    endtask

    task automatic test_store_io;
        fetch(SW);
        alu_result_high = IO_A;
        step();
        alu_result_high = '0;
        for (int i = 1; i <= 5; i++) begin
            io_ready = (i == 5);
            @(negedge clk);
            checks++;
            if (state !== 3'd3 || IOWrite !== 1'b1 || MemWrite !== 1'b0) begin
                errors++;
                $display("FAIL sw_io_cyc%0d: state=%0d IOWrite=%b MemWrite=%b expected 3/1/0",
                         i, state, IOWrite, MemWrite);
            end
            step();
        end
        io_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 3'd0 || pc_write !== 1'b1 || IOWrite !== 1'b0 || RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL sw_io_pc: state=%0d pc_write=%b IOWrite=%b RegWrite=%b expected 0/1/0/0",
                     state, pc_write, IOWrite, RegWrite);
        end
        step();
        @(negedge clk);
        checks++;
        if (pc_write !== 1'b0) begin
            errors++;
            $display("FAIL sw_io_pc_pulse: pc_write=%b expected 0", pc_write);
        end
    endtask

    task automatic test_bad_addr;
        fetch(LW);
        alu_result_high = 22'h000100;
        step();
        alu_result_high = '0;
        @(negedge clk);
        checks++;
        if (state !== 3'd3 || outs !== 22'd0) begin
            errors++;
            $display("FAIL bad_addr_mem: state=%0d outs=%h expected 3/0", state, outs);
        end
        step();
        @(negedge clk);
        checks++;
        if (state !== 3'd7 || outs !== 22'b101) begin
            errors++;
            $display("FAIL bad_addr_trap: state=%0d outs=%h expected 7/000005", state, outs);
        end
        do_reset();
    endtask

    task automatic test_illegal;
        instruction = ILL;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 3'd1 || trap !== 1'b0) begin
            errors++;
            $display("FAIL ill_decode: state=%0d trap=%b expected 1/0", state, trap);
        end
        step();
        @(negedge clk);
        checks++;
        if (state !== 3'd7 || outs !== 22'b100) begin
            errors++;
            $display("FAIL ill_trap: state=%0d outs=%h expected 7/000004", state, outs);
        end
        instruction = ADD;
        instr_valid = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (state !== 3'd7 || ir_write !== 1'b0 || trap !== 1'b1) begin
            errors++;
            $display("FAIL ill_sticky: state=%0d ir_write=%b trap=%b expected 7/0/1",
                     state, ir_write, trap);
        end
        do_reset();
    endtask

    task automatic test_muldiv;
`ifdef RV32M_EN
        fetch(MUL);
        alu_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (state !== 3'd2 || ALUop !== 4'hA) begin
                errors++;
                $display("FAIL mul_hold%0d: state=%0d ALUop=%h expected 2/a", i, state, ALUop);
            end
            step();
        end
        alu_done = 1'b1;
        step();
        alu_done = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 3'd4 || RegWrite !== 1'b1) begin
            errors++;
            $display("FAIL mul_wb: state=%0d RegWrite=%b expected 4/1", state, RegWrite);
        end
        step();
`else
        alu_done = 1'b1;
        instruction = MUL;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if (state !== 3'd7 || trap !== 1'b1 || trap_cause !== 2'd0) begin
            errors++;
            $display("FAIL mul_illegal: state=%0d trap=%b cause=%0d expected 7/1/0",
                     state, trap, trap_cause);
        end
        do_reset();
`endif
    endtask

    task automatic test_io_timeout;
        int n = 0;
        fetch(SW);
        alu_result_high = IO_A;
        step();
        alu_result_high = '0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (state !== 3'd3)
                break;
            if (IOWrite === 1'b1)
                n++;
            step();
        end
        checks++;
        if (n !== 255) begin
            errors++;
            $display("FAIL timeout_cycles: got %0d expected 255", n);
        end
        checks++;
        if (state !== 3'd7 || trap !== 1'b1 || trap_cause !== 2'd2 || IOWrite !== 1'b0) begin
            errors++;
            $display("FAIL timeout_trap: state=%0d trap=%b cause=%0d IOWrite=%b expected 7/1/2/0",
                     state, trap, trap_cause, IOWrite);
        end
        do_reset();
    endtask

    task automatic test_reset_mid_io;
        fetch(LW);
        alu_result_high = IO_A;
        step();
        alu_result_high = '0;
        step();
        @(negedge clk);
        checks++;
        if (state !== 3'd3 || IORead !== 1'b1) begin
            errors++;
            $display("FAIL rst_io_wait: state=%0d IORead=%b expected 3/1", state, IORead);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== 22'd0 || state !== 3'd0) begin
            errors++;
            $display("FAIL rst_io_async: outs=%h state=%0d expected 0/0", outs, state);
        end
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (state !== 3'd0 || outs !== 22'd0) begin
            errors++;
            $display("FAIL rst_io_release: state=%0d outs=%h expected 0/0", state, outs);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_branch();
        test_jal();
        test_load_ram();
        test_store_io();
        test_bad_addr();
        test_illegal();
        test_muldiv();
        test_io_timeout();
        test_reset_mid_io();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle RV32I control decoder.
- Latches the fetched instruction and sequences FETCH/DECODE/EXEC/MEM/WB, one enable set per phase.
- Adds configurable RAM/IO address windows, RAM wait states, an IO ready handshake with timeout, and a sticky trap state for illegal opcodes and bad addresses.
- Sits between IFetch, ALU, data memory, the MemOrIO bridge and the register file.

Parameters:
- ADDR_HI_W, 22, width of alu_result_high (address bits [31:10]).
- IO_HIGH, 22'h3FFFFF, alu_result_high value selecting the IO window (0xFFFFFC00-0xFFFFFFFF).
- RAM_LIMIT_HIGH, 22'h000040, alu_result_high strictly below this is RAM.
- MEM_WAIT, 1, RAM access cycles (1..15).
- IO_TIMEOUT, 255, max cycles waiting for io_ready (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instruction  in  32  instruction word from IFetch.
- instr_valid  in  1  instruction is valid this cycle.
- alu_result_high  in  ADDR_HI_W  ALU result bits [31:10], valid in EXEC.
- io_ready  in  1  IO device completed the access.
- alu_done  in  1  multi-cycle ALU op finished (used only with RV32M_EN).
- ir_write  out  1  instruction register load strobe.
- pc_write  out  1  PC update strobe.
- ALUop  out  4  ALU operation code.
- ALUSrc  out  1  selects immediate operand.
- sftmd  out  1  shift operation.
- branch_type  out  3  0 none, 1 beq, 2 bne, 3 blt, 4 bge, 5 bltu, 6 bgeu.
- jal, jalr  out  1 each  jump type.
- MemRead, MemWrite, IORead, IOWrite  out  1 each  access enables.
- MemorIOToReg  out  1  write-back source is memory/IO.
- RegWrite  out  1  register file write strobe.
- state  out  3  current state, for debug.
- trap  out  1  sticky fault flag.
- trap_cause  out  2  0 illegal opcode, 1 address fault, 2 IO timeout.

Behaviour:
- Reset (async, rst_n=0): state=FETCH (0); IR=0; every output 0; counters 0. Effect is immediate, even mid-access.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- All control outputs are registered or decoded from the latched IR and state. The live instruction input is used only in FETCH.
- FETCH:
  - ir_write=1 when instr_valid=1. IR is loaded at that edge; next state DECODE.
  - If instr_valid=0, stay in FETCH.
- DECODE: decode IR into the control registers.
  - Unknown opcode, or a funct3/funct7 combination not listed below -> TRAP with cause 0.
  - Otherwise -> EXEC.
- ALUop is one encoding shared by R- and I-type: add 0, sub 1, xor 2, or 3, and 4, sll 5, srl 6, sra 7, lui 8, auipc 9.
- sftmd=1 for sll, srl, sra and their immediate forms.
- ALUSrc=1 for I-type, load, store, jalr, lui and auipc.
- EXEC: ALUop, ALUSrc and branch_type are driven. Next state by class:
  - Load/store -> MEM.
  - Branch -> FETCH with pc_write=1 for 1 cycle; the datapath resolves taken or not-taken.
  - All other classes -> WB.
- MEM address class comes from alu_result_high, sampled on the EXEC->MEM edge and held:
  - RAM: MemRead or MemWrite held for MEM_WAIT cycles.
  - IO: IORead or IOWrite held until io_ready=1, including the same cycle io_ready rises. The cycle count starts at 1.
  - If io_ready is not seen within IO_TIMEOUT cycles -> TRAP with cause 2.
  - Neither RAM nor IO -> TRAP with cause 1; no enable is asserted.
  - After MEM: loads -> WB with MemorIOToReg=1; stores -> FETCH with pc_write=1.
- WB: RegWrite=1 and pc_write=1 for exactly 1 cycle; jal/jalr stay valid through this cycle. Next state FETCH.
- Instruction latency: ALU ops 4 cycles; loads 4+MEM_WAIT (RAM); stores 3+MEM_WAIT; branches 3.
- TRAP: every enable and strobe is 0; trap=1 and trap_cause are held until reset. instr_valid is ignored.
- Simultaneous events: io_ready on the cycle the timeout count is reached counts as success. Reset overrides everything.

Optional Feature:
- Macro: RV32M_EN.
- Defined:
  - opcode 0110011 with funct7=0000001 decodes to mul A, mulh B, div C, rem D (funct3 000, 001, 100, 110); other funct3 values are illegal.
  - EXEC holds the ALUop until alu_done=1, then -> WB.
- Undefined: these encodings are illegal -> TRAP with cause 0. alu_done is ignored.

Test Plan:
- Reset mid-IO-wait: assert rst_n=0 during MEM with IORead=1 -> all outputs 0 immediately; state=0 after release.
- add x3,x1,x2 (0x002081B3), instr_valid=1:
  - ir_write in cycle 0; ALUop=0 in EXEC; RegWrite=1 and pc_write=1 in cycle 3; back to FETCH.
- lw, alu_result_high=0x000010, MEM_WAIT=2 -> MemRead=1 for exactly 2 cycles, then WB with MemorIOToReg=1 and RegWrite=1.
- sw, alu_result_high=0x3FFFFF, io_ready after 5 cycles -> IOWrite=1 for 5 cycles, then pc_write in the next state FETCH.
- Same sw with io_ready never asserted -> TRAP after IO_TIMEOUT=255 cycles; trap_cause=2; IOWrite=0.
- Illegal opcode 0x0000007F -> TRAP after DECODE with trap_cause=0.
- With RV32M_EN, mul (0x022081B3) -> ALUop=A until alu_done.
- Without RV32M_EN, the same mul -> trap_cause=0.
